// File: rtl/radix4_div16.sv
// radix4_div16: 16-bit radix-4 restoring divider with valid/ready handshakes, 8-cycle CALC.
// Define DIV_SIGNED_EN for two's-complement truncating division; default build is unsigned.
module radix4_div16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Q,
    output logic [15:0] R,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_rem, r_dvd, r_quo, r_div, r_q, r_r;
    logic        r_dbz, r_ov;
    logic [15:0] w_a_mag, w_b_mag, w_q_fin, w_r_fin, w_rem_nxt, w_quo_nxt;
    logic [17:0] w_sh, w_b1, w_b2, w_b3;
    logic        w_ge1, w_ge2, w_ge3;
    logic [1:0]  w_dig;
    assign w_sh  = {r_rem, r_dvd[15:14]};
    assign w_b1  = {2'b00, r_div};
    assign w_b2  = {1'b0, r_div, 1'b0};
    assign w_b3  = w_b1 + w_b2;
    assign w_ge1 = w_sh >= w_b1;
    assign w_ge2 = w_sh >= w_b2;
    assign w_ge3 = w_sh >= w_b3;
    assign w_dig = {w_ge2, w_ge3 | (w_ge1 & ~w_ge2)};
    // the true remainder is below the divisor, so 16-bit modular subtraction is exact
    assign w_rem_nxt = w_ge3 ? w_sh[15:0] - w_b3[15:0] :
                       w_ge2 ? w_sh[15:0] - w_b2[15:0] :
                       w_ge1 ? w_sh[15:0] - w_b1[15:0] : w_sh[15:0];
    assign w_quo_nxt = {r_quo[13:0], w_dig};
`ifdef DIV_SIGNED_EN
    logic r_neg_q, r_neg_r;
    assign w_a_mag = A[15] ? -A : A;
    assign w_b_mag = B[15] ? -B : B;
    assign w_q_fin = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fin = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_neg_q <= A[15] ^ B[15];
            r_neg_r <= A[15];
        end
`else
    assign w_a_mag = A;
    assign w_b_mag = B;
    assign w_q_fin = w_quo_nxt;
    assign w_r_fin = w_rem_nxt;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rem   <= 16'd0;
            r_dvd   <= 16'd0;
            r_quo   <= 16'd0;
            r_div   <= 16'd0;
            r_q     <= 16'd0;
            r_r     <= 16'd0;
            r_dbz   <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_dvd <= w_a_mag;
                    r_div <= w_b_mag;
                    r_rem <= 16'd0;
                    r_quo <= 16'd0;
                    if (B == 16'd0) begin
                        r_q     <= 16'hFFFF;
                        r_r     <= A;
                        r_dbz   <= 1'b1;
                        r_ov    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= 4'd7;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_dvd <= {r_dvd[13:0], 2'b00};
                    if (r_cnt == 4'd0) begin
                        r_q     <= w_q_fin;
                        r_r     <= w_r_fin;
                        r_dbz   <= 1'b0;
                        r_ov    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: if (out_ready) begin
                    r_ov    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_ov;
    assign Q           = r_q;
    assign R           = r_r;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_radix4_div16.sv
// tb_radix4_div16: directed scenario tests for radix4_div16 (either DIV_SIGNED_EN build).
module tb_radix4_div16;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] A = 16'd0, B = 16'd0;
    logic        in_ready, out_valid, div_by_zero;
    logic [15:0] Q, R;
    int          n_vec = 0, n_err = 0;
`ifdef DIV_SIGNED_EN
    localparam logic [15:0] NQ1 = 16'hFFFD, NR1 = 16'hFFFF, NQ2 = 16'h8000, NR2 = 16'h0000;
`else
    localparam logic [15:0] NQ1 = 16'h7FFC, NR1 = 16'h0001, NQ2 = 16'h0000, NR2 = 16'h8000;
`endif

    radix4_div16 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .R(R), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        in_valid = 1'b1; A = 16'd5; B = 16'd1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if ({Q, R, div_by_zero} !== 33'd0) begin n_err++; $display("FAIL rst_outputs: got Q=%h R=%h dbz=%b want 0", Q, R, div_by_zero); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_no_accept: got ov=%b ir=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_basic;
        int lat;
        accept(16'd100, 16'd7);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy: got in_ready=%b want 0", in_ready); end
        wait_out(lat);
        n_vec++; if (lat !== 8) begin n_err++; $display("FAIL basic_latency: got %0d want 8", lat); end
        n_vec++; if (Q !== 16'd14 || R !== 16'd2 || div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_result: got Q=%0d R=%0d dbz=%b want 14/2/0", Q, R, div_by_zero); end
        release_out;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || Q !== 16'd14 || R !== 16'd2) begin n_err++; $display("FAIL basic_after: got ov=%b ir=%b Q=%0d R=%0d want 0/1/14/2", out_valid, in_ready, Q, R); end
    endtask

    task automatic test_div_zero;
        int lat;
        accept(16'h1234, 16'h0000);
        wait_out(lat);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL dbz_latency: got %0d want 1", lat); end
        n_vec++; if (Q !== 16'hFFFF || R !== 16'h1234 || div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_result: got Q=%h R=%h dbz=%b want ffff/1234/1", Q, R, div_by_zero); end
        release_out;
        n_vec++; if (out_valid !== 1'b0 || div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_after: got ov=%b dbz=%b want 0/1", out_valid, div_by_zero); end
    endtask

    task automatic test_stall;
        int lat;
        accept(16'hFFFF, 16'h0001);
        wait_out(lat);
        n_vec++; if (lat !== 8) begin n_err++; $display("FAIL stall_latency: got %0d want 8", lat); end
        in_valid = 1'b1; A = 16'd3; B = 16'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || Q !== 16'hFFFF || R !== 16'h0000 || div_by_zero !== 1'b0)
                begin n_err++; $display("FAIL stall_hold%0d: got ov=%b ir=%b Q=%h R=%h dbz=%b want 1/0/ffff/0000/0", i, out_valid, in_ready, Q, R, div_by_zero); end
        end
        in_valid = 1'b0;
        release_out;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || Q !== 16'hFFFF || R !== 16'h0000) begin n_err++; $display("FAIL stall_release: got ov=%b ir=%b Q=%h R=%h want 0/1/ffff/0000", out_valid, in_ready, Q, R); end
    endtask

    task automatic test_abort;
        int  lat;
        logic seen;
        accept(16'd1000, 16'd3);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL abort_state: got ov=%b ir=%b want 0/1", out_valid, in_ready); end
        n_vec++; if ({Q, R, div_by_zero} !== 33'd0) begin n_err++; $display("FAIL abort_outputs: got Q=%h R=%h dbz=%b want 0", Q, R, div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_result: got out_valid seen=%b want 0", seen); end
        accept(16'd9, 16'd4);
        wait_out(lat);
        n_vec++; if (lat !== 8 || Q !== 16'd2 || R !== 16'd1) begin n_err++; $display("FAIL abort_next: got lat=%0d Q=%0d R=%0d want 8/2/1", lat, Q, R); end
        release_out;
    endtask

    task automatic test_sign;
        int lat;
        accept(16'hFFF9, 16'h0002);
        wait_out(lat);
        n_vec++; if (lat !== 8 || Q !== NQ1 || R !== NR1) begin n_err++; $display("FAIL sign_neg7_by_2: got lat=%0d Q=%h R=%h want 8/%h/%h", lat, Q, R, NQ1, NR1); end
        release_out;
        accept(16'h8000, 16'hFFFF);
        wait_out(lat);
        n_vec++; if (lat !== 8 || Q !== NQ2 || R !== NR2 || div_by_zero !== 1'b0) begin n_err++; $display("FAIL sign_min_by_m1: got lat=%0d Q=%h R=%h dbz=%b want 8/%h/%h/0", lat, Q, R, div_by_zero, NQ2, NR2); end
        release_out;
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        A = 16'd50; B = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_first_accept: got in_ready=%b want 0", in_ready); end
        A = 16'd200; B = 16'd9;
        wait_out(lat);
        n_vec++; if (lat !== 8 || Q !== 16'd10 || R !== 16'd0) begin n_err++; $display("FAIL b2b_first: got lat=%0d Q=%0d R=%0d want 8/10/0", lat, Q, R); end
        @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_handshake: got ov=%b ir=%b want 0/1", out_valid, in_ready); end
        @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept: got in_ready=%b want 0", in_ready); end
        in_valid = 1'b0;
        wait_out(lat);
        n_vec++; if (lat !== 8 || Q !== 16'd22 || R !== 16'd2 || div_by_zero !== 1'b0) begin n_err++; $display("FAIL b2b_second: got lat=%0d Q=%0d R=%0d dbz=%b want 8/22/2/0", lat, Q, R, div_by_zero); end
        @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_done: got out_valid=%b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_stall;
        test_abort;
        test_sign;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
